// File: rtl/fft_stage5_seq.sv
// fft_stage5_seq: final radix-2 DIT stage of a 32-point fixed-point FFT.
// One time-multiplexed, two-stage pipelined butterfly walks pairs (k, k+16)
// with twiddle W32^k. All 32 results are published together with a finish pulse.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stage5_start          one-cycle pulse, captures in_*/tw_* when idle
//   stage5_Finish         one-cycle pulse, out_* updated this cycle
//   busy                  high from capture through the finish cycle
//   in_real/in_imag       32 samples, element i at [i*DW +: DW]
//   tw_real/tw_imag       16 twiddles, element k at [k*DW +: DW]
//   out_real/out_imag     32 results, element i at [i*DW +: DW]
module fft_stage5_seq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned INTEGER    = 4,
    parameter int unsigned FRACTION   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stage5_start,
    output logic                       stage5_Finish,
    output logic                       busy,
    input  logic [32*DATA_WIDTH-1:0]   in_real,
    input  logic [32*DATA_WIDTH-1:0]   in_imag,
    input  logic [16*DATA_WIDTH-1:0]   tw_real,
    input  logic [16*DATA_WIDTH-1:0]   tw_imag,
    output logic [32*DATA_WIDTH-1:0]   out_real,
    output logic [32*DATA_WIDTH-1:0]   out_imag
);

    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned N      = 32;
    localparam int unsigned HALF   = 16;
    localparam int unsigned PROD_W = 2 * (INTEGER + FRACTION);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        state_q;
    logic [3:0]    k_q;

    // Input bank (captured at start) and result bank
    logic [DW-1:0] x_re_q [N];
    logic [DW-1:0] x_im_q [N];
    logic [DW-1:0] w_re_q [HALF];
    logic [DW-1:0] w_im_q [HALF];
    logic [DW-1:0] r_re_q [N];
    logic [DW-1:0] r_im_q [N];

    // Butterfly stage-1 registers: a and the scaled product p = b*W
    logic          s1_v_q;
    logic [3:0]    s1_idx_q;
    logic [DW-1:0] s1_a_re_q;
    logic [DW-1:0] s1_a_im_q;
    logic [DW-1:0] s1_p_re_q;
    logic [DW-1:0] s1_p_im_q;

    logic signed [DW-1:0]     b_re_c, b_im_c, w_re_c, w_im_c;
    logic signed [PROD_W-1:0] rr_c, ii_c, ri_c, ir_c;
    logic [DW-1:0]            p_re_c, p_im_c;
    logic [DW-1:0]            sum_re_c, sum_im_c, dif_re_c, dif_im_c;
    logic [4:0]               lo_idx_c, hi_idx_c;

    // Stage 1: complex multiply of b = x[k+16] by W = w[k]; one extra bit
    // holds the sum/difference before the floor shift and truncation.
    always_comb begin
        b_re_c = x_re_q[{1'b1, k_q}];
        b_im_c = x_im_q[{1'b1, k_q}];
        w_re_c = w_re_q[k_q];
        w_im_c = w_im_q[k_q];
        rr_c   = b_re_c * w_re_c;
        ii_c   = b_im_c * w_im_c;
        ri_c   = b_re_c * w_im_c;
        ir_c   = b_im_c * w_re_c;
        p_re_c = DW'(($signed({rr_c[PROD_W-1], rr_c}) - $signed({ii_c[PROD_W-1], ii_c})) >>> FRACTION);
        p_im_c = DW'(($signed({ri_c[PROD_W-1], ri_c}) + $signed({ir_c[PROD_W-1], ir_c})) >>> FRACTION);
    end

    // Stage 2: modular add/subtract of the pair held in stage 1
    always_comb begin
        sum_re_c = s1_a_re_q + s1_p_re_q;
        sum_im_c = s1_a_im_q + s1_p_im_q;
        dif_re_c = s1_a_re_q - s1_p_re_q;
        dif_im_c = s1_a_im_q - s1_p_im_q;
        lo_idx_c = {1'b0, s1_idx_q};
        hi_idx_c = {1'b1, s1_idx_q};
    end

    // Control FSM, pipeline and banks
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            busy          <= 1'b0;
            stage5_Finish <= 1'b0;
            s1_v_q        <= 1'b0;
            s1_idx_q      <= '0;
            s1_a_re_q     <= '0;
            s1_a_im_q     <= '0;
            s1_p_re_q     <= '0;
            s1_p_im_q     <= '0;
            out_real      <= '0;
            out_imag      <= '0;
            for (int i = 0; i < N; i++) begin
                x_re_q[i] <= '0;
                x_im_q[i] <= '0;
                r_re_q[i] <= '0;
                r_im_q[i] <= '0;
            end
            for (int j = 0; j < HALF; j++) begin
                w_re_q[j] <= '0;
                w_im_q[j] <= '0;
            end
        end else begin
            stage5_Finish <= 1'b0;
            s1_v_q        <= 1'b0;

            if (s1_v_q) begin
                r_re_q[lo_idx_c] <= sum_re_c;
                r_im_q[lo_idx_c] <= sum_im_c;
                r_re_q[hi_idx_c] <= dif_re_c;
                r_im_q[hi_idx_c] <= dif_im_c;
            end

            case (state_q)
                S_IDLE: begin
                    busy <= stage5_start;
                    if (stage5_start) begin
                        for (int i = 0; i < N; i++) begin
                            x_re_q[i] <= in_real[i*DW +: DW];
                            x_im_q[i] <= in_imag[i*DW +: DW];
                        end
                        for (int j = 0; j < HALF; j++) begin
                            w_re_q[j] <= tw_real[j*DW +: DW];
                            w_im_q[j] <= tw_imag[j*DW +: DW];
                        end
                        k_q     <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    s1_v_q    <= 1'b1;
                    s1_idx_q  <= k_q;
                    s1_a_re_q <= x_re_q[{1'b0, k_q}];
                    s1_a_im_q <= x_im_q[{1'b0, k_q}];
                    s1_p_re_q <= p_re_c;
                    s1_p_im_q <= p_im_c;
                    k_q       <= k_q + 4'd1;
                    if (k_q == 4'(HALF - 1)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Publish the bank with the final in-flight pair merged in
                    for (int i = 0; i < N; i++) begin
                        out_real[i*DW +: DW] <= r_re_q[i];
                        out_imag[i*DW +: DW] <= r_im_q[i];
                    end
                    out_real[lo_idx_c*DW +: DW] <= sum_re_c;
                    out_imag[lo_idx_c*DW +: DW] <= sum_im_c;
                    out_real[hi_idx_c*DW +: DW] <= dif_re_c;
                    out_imag[hi_idx_c*DW +: DW] <= dif_im_c;
                    stage5_Finish <= 1'b1;
                    state_q       <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage5_seq.sv
// Scoreboard bench for fft_stage5_seq: directed vectors with hand-computed
// results, a monitor that checks each finish against the queued expectation,
// plus cycle-level checks of busy/finish timing, start masking and reset.
module tb_fft_stage5_seq;

    localparam int DW = 8;

    logic            clk;
    logic            reset;
    logic            stage5_start;
    logic            stage5_Finish;
    logic            busy;
    logic [32*DW-1:0] in_real;
    logic [32*DW-1:0] in_imag;
    logic [16*DW-1:0] tw_real;
    logic [16*DW-1:0] tw_imag;
    logic [32*DW-1:0] out_real;
    logic [32*DW-1:0] out_imag;

    typedef struct packed {
        logic [32*DW-1:0] re;
        logic [32*DW-1:0] im;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   finishes = 0;

    logic [7:0] in_re [32];
    logic [7:0] in_im [32];
    logic [7:0] tw_re [16];
    logic [7:0] tw_im [16];
    logic [7:0] ex_re [32];
    logic [7:0] ex_im [32];

    fft_stage5_seq dut (
        .clk          (clk),
        .reset        (reset),
        .stage5_start (stage5_start),
        .stage5_Finish(stage5_Finish),
        .busy         (busy),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .tw_real      (tw_real),
        .tw_imag      (tw_imag),
        .out_real     (out_real),
        .out_imag     (out_imag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector 0: W=1, a=1.0, b=0.5. Vector 1: vector 0 with hand-picked pairs.
    // Vector 2: filler data that must never reach the outputs.
    task automatic set_vec(input int v);
        for (int k = 0; k < 16; k++) begin
            in_re[k] = 8'h10; in_im[k] = 8'h00;
            in_re[k+16] = 8'h08; in_im[k+16] = 8'h00;
            tw_re[k] = 8'h10; tw_im[k] = 8'h00;
            ex_re[k] = 8'h18; ex_im[k] = 8'h00;
            ex_re[k+16] = 8'h08; ex_im[k+16] = 8'h00;
        end
        if (v == 1) begin
            // k=0: W=1+j, a=0, b=1+j -> p=0+2j
            tw_re[0] = 8'h10; tw_im[0] = 8'h10;
            in_re[0] = 8'h00; in_re[16] = 8'h10; in_im[16] = 8'h10;
            ex_re[0] = 8'h00; ex_im[0] = 8'h20; ex_re[16] = 8'h00; ex_im[16] = 8'hE0;
            // k=1: complex a and b, W=1
            in_re[1] = 8'h10; in_im[1] = 8'h20; in_re[17] = 8'h08; in_im[17] = 8'h18;
            ex_re[1] = 8'h18; ex_im[1] = 8'h38; ex_re[17] = 8'h08; ex_im[17] = 8'h08;
            // k=2: W=0.5+0.5j, b=1+2j -> p=-0.5+1.5j
            tw_re[2] = 8'h08; tw_im[2] = 8'h08;
            in_re[2] = 8'h01; in_im[2] = 8'h02; in_re[18] = 8'h10; in_im[18] = 8'h20;
            ex_re[2] = 8'hF9; ex_im[2] = 8'h1A; ex_re[18] = 8'h09; ex_im[18] = 8'hEA;
            // k=3: wrap
            in_re[3] = 8'h70; in_re[19] = 8'h70;
            ex_re[3] = 8'hE0; ex_re[19] = 8'h00;
            // k=5: floor of -1/32
            tw_re[5] = 8'h08;
            in_re[5] = 8'h00; in_re[21] = 8'hFF;
            ex_re[5] = 8'hFF; ex_re[21] = 8'h01;
            // k=8: W=-j
            tw_re[8] = 8'h00; tw_im[8] = 8'hF0;
            in_re[8] = 8'h10; in_re[24] = 8'h10;
            ex_re[8] = 8'h10; ex_im[8] = 8'hF0; ex_re[24] = 8'h10; ex_im[24] = 8'h10;
            // k=15 (last pair, merged at drain): W=-1, a=2, b=0.25+0.125j
            tw_re[15] = 8'hF0; tw_im[15] = 8'h00;
            in_re[15] = 8'h20; in_re[31] = 8'h04; in_im[31] = 8'h02;
            ex_re[15] = 8'h1C; ex_im[15] = 8'hFE; ex_re[31] = 8'h24; ex_im[31] = 8'h02;
        end else if (v == 2) begin
            for (int i = 0; i < 32; i++) begin
                in_re[i] = 8'h33; in_im[i] = 8'h5A;
            end
            for (int k = 0; k < 16; k++) begin
                tw_re[k] = 8'h33; tw_im[k] = 8'hC4;
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 32; i++) begin
            in_real[i*DW +: DW] = in_re[i];
            in_imag[i*DW +: DW] = in_im[i];
        end
        for (int k = 0; k < 16; k++) begin
            tw_real[k*DW +: DW] = tw_re[k];
            tw_imag[k*DW +: DW] = tw_im[k];
        end
    endtask

    // Present vector v with start high; optionally queue its expected result
    task automatic launch(input int v, input bit expect_finish);
        exp_t e;
        set_vec(v);
        drive_inputs();
        if (expect_finish) begin
            for (int i = 0; i < 32; i++) begin
                e.re[i*DW +: DW] = ex_re[i];
                e.im[i*DW +: DW] = ex_im[i];
            end
            exp_q.push_back(e);
        end
        stage5_start = 1'b1;
    endtask

    // Clock the start edge, then check each cycle up to and including finish
    task automatic watch(input string tag, input bit ignore_starts);
        logic [32*DW-1:0] prev_re;
        logic [32*DW-1:0] prev_im;
        prev_re = out_real;
        prev_im = out_imag;
        tick();
        stage5_start = 1'b0;
        for (int t = 0; t <= 17; t++) begin
            check({tag, " busy"}, 256'(busy), 256'(1'b1));
            check({tag, " finish"}, 256'(stage5_Finish), 256'(t == 17));
            if (t < 17) begin
                check({tag, " out_real held"}, out_real, prev_re);
                check({tag, " out_imag held"}, out_imag, prev_im);
                if (ignore_starts && (t == 4 || t == 9)) begin
                    set_vec(2);
                    drive_inputs();
                    stage5_start = 1'b1;
                end
                tick();
                stage5_start = 1'b0;
            end
        end
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (stage5_Finish === 1'b1) begin
                finishes++;
                check("sb expectation pending", 256'(exp_q.size() > 0), 256'(1'b1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb out_real", out_real, e.re);
                    check("sb out_imag", out_imag, e.im);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        reset = 1'b1;
        stage5_start = 1'b0;
        set_vec(2);
        drive_inputs();
        repeat (3) tick();
        check("reset busy", 256'(busy), 256'(1'b0));
        check("reset finish", 256'(stage5_Finish), 256'(1'b0));
        check("reset out_real", out_real, '0);
        check("reset out_imag", out_imag, '0);
        reset = 1'b0;
        tick();

        // Basic run, then idle afterwards
        launch(0, 1'b1);
        watch("runA", 1'b0);
        tick();
        check("runA idle busy", 256'(busy), 256'(1'b0));
        check("runA idle finish", 256'(stage5_Finish), 256'(1'b0));

        // Run with ignored mid-run starts, then a start in its finish cycle
        launch(1, 1'b1);
        watch("runB", 1'b1);
        launch(0, 1'b1);
        watch("b2b", 1'b0);
        tick();
        check("b2b idle busy", 256'(busy), 256'(1'b0));

        // Reset in the middle of a run
        launch(1, 1'b0);
        tick();
        stage5_start = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 256'(busy), 256'(1'b0));
        check("abort finish", 256'(stage5_Finish), 256'(1'b0));
        check("abort out_real", out_real, '0);
        check("abort out_imag", out_imag, '0);
        f0 = finishes;
        repeat (25) tick();
        check("abort no finish", 256'(finishes - f0), 256'(0));

        // Reset together with start
        reset = 1'b1;
        launch(1, 1'b0);
        tick();
        reset = 1'b0;
        stage5_start = 1'b0;
        tick();
        check("rst+start busy", 256'(busy), 256'(1'b0));
        f0 = finishes;
        repeat (25) tick();
        check("rst+start no finish", 256'(finishes - f0), 256'(0));
        check("rst+start out_real", out_real, '0);

        // Recovery run
        launch(1, 1'b1);
        watch("runB2", 1'b0);
        tick();

        check("sb drained", 256'(exp_q.size()), 256'(0));
        check("finish count", 256'(finishes), 256'(4));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
